// File: rtl/secure_password_vault.sv
// Sixteen-entry encrypted password store: XOR+rotate cipher on the write path,
// inverse on the read path, and plaintext release only with the master password.
`timescale 1ns/1ps
module secure_password_vault #(
    parameter logic [7:0]  MASTER_PASS = 8'hA5,
    parameter int unsigned DEPTH       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key,
    input  logic [7:0] plain_in,
    output logic [7:0] enc_out,
    input  logic       write_en,
    input  logic [3:0] write_addr,
    input  logic [3:0] read_addr,
    output logic [7:0] stored_cipher,
    input  logic [7:0] entered_pass,
    output logic       unlocked,
    output logic [7:0] dec_out,
    output logic       dec_valid
);

    localparam int unsigned DW = 8;

    logic [DW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;

    logic [DW-1:0] w_xor;
    logic [DW-1:0] w_rd_cipher;
    logic [DW-1:0] w_rd_rot;
    logic [DW-1:0] w_dec;
    logic          w_unlocked;

    // Encrypt: XOR with key, then rotate left by 3.
    assign w_xor   = plain_in ^ key;
    assign enc_out = {w_xor[4:0], w_xor[7:5]};

    assign w_unlocked = (entered_pass == MASTER_PASS);
    assign unlocked   = w_unlocked;

    // Storage; reset clears every entry and has priority over a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_valid <= '0;
        end else if (write_en) begin
            r_mem[write_addr]   <= enc_out;
            r_valid[write_addr] <= 1'b1;
        end
    end

    // Decrypt with the current key: rotate right by 3, then XOR.
    assign w_rd_cipher   = r_mem[read_addr];
    assign w_rd_rot      = {w_rd_cipher[2:0], w_rd_cipher[7:3]};
    assign w_dec         = w_rd_rot ^ key;
    assign stored_cipher = w_rd_cipher;
    assign dec_out       = w_unlocked ? w_dec : 8'h00;
    assign dec_valid     = w_unlocked & r_valid[read_addr];

endmodule

// File: tb/tb_secure_password_vault.sv
// Directed bench for secure_password_vault: a per-cycle vector table for store,
// lock and unlock behaviour, then hand sequences for async reset and collisions.
`timescale 1ns/1ps
module tb_secure_password_vault;

    logic       clk;
    logic       rst_n;
    logic [7:0] key;
    logic [7:0] plain_in;
    logic [7:0] enc_out;
    logic       write_en;
    logic [3:0] write_addr;
    logic [3:0] read_addr;
    logic [7:0] stored_cipher;
    logic [7:0] entered_pass;
    logic       unlocked;
    logic [7:0] dec_out;
    logic       dec_valid;

    int n_vec;
    int n_err;

    secure_password_vault dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key          (key),
        .plain_in     (plain_in),
        .enc_out      (enc_out),
        .write_en     (write_en),
        .write_addr   (write_addr),
        .read_addr    (read_addr),
        .stored_cipher(stored_cipher),
        .entered_pass (entered_pass),
        .unlocked     (unlocked),
        .dec_out      (dec_out),
        .dec_valid    (dec_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [3:0] ra;
        logic [7:0] key;
        logic [7:0] plain;
        logic [7:0] pass;
        logic [7:0] e_enc;
        logic [7:0] e_cipher;
        logic       e_unl;
        logic [7:0] e_dec;
        logic       e_dv;
    } vec_t;

    vec_t vt[$];

    // Hand-computed ciphers of the plains below under key A5.
    logic [7:0] plains  [10] = '{8'h12, 8'h3A, 8'h5F, 8'h9B, 8'h04, 8'hE7, 8'hAC, 8'hD1, 8'h23, 8'h7C};
    logic [7:0] ciphers [10] = '{8'hBD, 8'hFC, 8'hD7, 8'hF1, 8'h0D, 8'h12, 8'h48, 8'hA3, 8'h34, 8'hCE};

    function automatic vec_t mk(logic we, logic [3:0] wa, logic [3:0] ra, logic [7:0] k,
                                logic [7:0] p, logic [7:0] pw, logic [7:0] e_enc,
                                logic [7:0] e_cipher, logic e_unl, logic [7:0] e_dec, logic e_dv);
        vec_t v;
        v.we = we; v.wa = wa; v.ra = ra; v.key = k; v.plain = p; v.pass = pw;
        v.e_enc = e_enc; v.e_cipher = e_cipher; v.e_unl = e_unl; v.e_dec = e_dec; v.e_dv = e_dv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] e_enc, input logic [7:0] e_cipher,
                             input logic e_unl, input logic [7:0] e_dec, input logic e_dv);
        check(name, {6'd0, enc_out, stored_cipher, unlocked, dec_out, dec_valid},
                    {6'd0, e_enc, e_cipher, e_unl, e_dec, e_dv});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        key = 8'hA5;
        plain_in = 8'h12;
        write_en = 1'b0;
        write_addr = 4'd0;
        read_addr = 4'd0;
        entered_pass = 8'hFF;

        // Encrypt path and cleared storage while still in reset.
        #2;
        check_all("reset_state", 8'hBD, 8'h00, 1'b0, 8'h00, 1'b0);
        plain_in = 8'h3A;
        #1;
        check("enc_3A", {24'd0, enc_out}, 32'h0000_00FC);
        @(negedge clk);
        rst_n = 1'b1;

        // Store rows: pre-edge reads show the old (cleared) entry at the write address.
        for (int i = 0; i < 10; i++)
            vt.push_back(mk(1'b1, 4'(i), 4'(i), 8'hA5, plains[i], 8'hFF, ciphers[i], 8'h00, 1'b0, 8'h00, 1'b0));
        vt.push_back(mk(1'b0, 4'd0, 4'd0, 8'hA5, 8'h00, 8'hFF, 8'h2D, 8'hBD, 1'b0, 8'h00, 1'b0));
        for (int i = 0; i < 10; i++)
            vt.push_back(mk(1'b0, 4'd0, 4'(i), 8'hA5, 8'h00, 8'hFF, 8'h2D, ciphers[i], 1'b0, 8'h00, 1'b0));
        for (int i = 0; i < 10; i++)
            vt.push_back(mk(1'b0, 4'd0, 4'(i), 8'hA5, 8'h00, 8'hA5, 8'h2D, ciphers[i], 1'b1, plains[i], 1'b1));
        vt.push_back(mk(1'b0, 4'd0, 4'd10, 8'hA5, 8'h00, 8'hA5, 8'h2D, 8'h00, 1'b1, 8'hA5, 1'b0));
        vt.push_back(mk(1'b0, 4'd0, 4'd1, 8'h3C, 8'h00, 8'hA5, 8'hE1, 8'hFC, 1'b1, 8'hA3, 1'b1));
        vt.push_back(mk(1'b0, 4'd0, 4'd2, 8'hA5, 8'h00, 8'hA4, 8'h2D, 8'hD7, 1'b0, 8'h00, 1'b0));

        foreach (vt[i]) begin
            @(negedge clk);
            write_en     = vt[i].we;
            write_addr   = vt[i].wa;
            read_addr    = vt[i].ra;
            key          = vt[i].key;
            plain_in     = vt[i].plain;
            entered_pass = vt[i].pass;
            #1;
            check_all($sformatf("vec%0d", i), vt[i].e_enc, vt[i].e_cipher, vt[i].e_unl, vt[i].e_dec, vt[i].e_dv);
        end

        // Asynchronous reset mid-cycle, with a write attempted while it is held.
        @(negedge clk);
        write_en = 1'b0;
        key = 8'hA5;
        plain_in = 8'h12;
        entered_pass = 8'hA5;
        read_addr = 4'd0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("rst_async_a0", 8'hBD, 8'h00, 1'b1, 8'hA5, 1'b0);
        write_en = 1'b1;
        write_addr = 4'd5;
        for (int i = 1; i < 10; i++) begin
            read_addr = 4'(i);
            #1;
            check($sformatf("rst_cipher%0d", i), {23'd0, stored_cipher, dec_valid}, 32'h0);
        end
        read_addr = 4'd5;
        @(posedge clk);
        #1;
        check("rst_write_blocked", {23'd0, stored_cipher, dec_valid}, 32'h0);
        write_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_a5", {23'd0, stored_cipher, dec_valid}, 32'h0);

        // Same-address write and read: old value before the edge, new after.
        @(negedge clk);
        write_en = 1'b1;
        write_addr = 4'd3;
        read_addr = 4'd3;
        plain_in = 8'h5F;
        #1;
        check_all("coll_pre", 8'hD7, 8'h00, 1'b1, 8'hA5, 1'b0);
        @(posedge clk);
        #1;
        check_all("coll_post", 8'hD7, 8'hD7, 1'b1, 8'h5F, 1'b1);
        @(negedge clk);
        plain_in = 8'h04;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        #1;
        check_all("overwrite", 8'h0D, 8'h0D, 1'b1, 8'h04, 1'b1);
        read_addr = 4'd0;
        #1;
        check("other_entry", {23'd0, stored_cipher, dec_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
